// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU memory port: size codes, op bit positions,
// FSM states and the alignment/illegal-op fault predicate.
package lsu_pkg;

  localparam int OP_STORE    = 3;
  localparam int OP_UNSIGNED = 2;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_e;

  function automatic int unsigned size_bytes(input logic [1:0] size);
    return 32'd1 << size;
  endfunction

  // off is the byte lane offset zero-extended to 3 bits; has_dword is set on 64-bit ports.
  function automatic logic is_fault(input logic [3:0] op, input logic [2:0] off,
                                    input logic has_dword);
    logic [2:0] mask;
    mask = 3'(size_bytes(op[1:0]) - 32'd1);
    return ((op[1:0] == SZ_D) && !has_dword) ||
           ((off & mask) != 3'b000) ||
           (op[OP_STORE] && op[OP_UNSIGNED]);
  endfunction

endpackage

// File: rtl/lsu_mem_port_lane_ext.sv
// Load lane extraction: shifts the addressed bytes down to bit 0 and sign/zero-extends
// them to the full data width according to the access size.
module lsu_mem_port_lane_ext
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]            rdata_i,
  input  logic [$clog2(DATA_W/8)-1:0]  off_i,
  input  logic [1:0]                   size_i,
  input  logic                         unsigned_i,
  output logic [DATA_W-1:0]            ext_o
);

  localparam int IDX_W = $clog2(DATA_W);

  logic [DATA_W-1:0] shifted;
  int unsigned       nbits;
  logic [IDX_W-1:0]  msb;
  logic              sign;

  // NOTE: every variable assigned in always_comb gets a value on every path first; a
  // path that skips an assignment would infer a latch.
  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    nbits   = 32'd8 * size_bytes(size_i);
    msb     = (int'(nbits) >= DATA_W) ? IDX_W'(DATA_W - 1) : IDX_W'(nbits - 32'd1);
    sign    = !unsigned_i && shifted[msb];
    ext_o   = '0;
    for (int i = 0; i < DATA_W; i++) begin
      ext_o[i] = (i < int'(nbits)) ? shifted[i] : sign;
    end
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store port between the MEM stage and a variable-latency data memory: one
// outstanding request, byte-lane steering for stores, extension of load data.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [3:0]          cmd_op,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W/8-1:0] mem_req_be,
  output logic [DATA_W-1:0]   mem_req_wdata,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_rdata,
  output logic                done_valid,
  output logic [DATA_W-1:0]   done_rdata,
  output logic                done_err,
  output logic                busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);

  state_e              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   result_q, result_d;

  logic [OFF_W-1:0]    cmd_off;
  logic [BE_W-1:0]     cmd_be;
  logic [DATA_W-1:0]   ext_data;
  logic                accept;

  assign cmd_off   = cmd_addr[OFF_W-1:0];
  assign cmd_ready = (state_q == S_IDLE) && reset_n;
  assign accept    = cmd_valid && cmd_ready;

  // Stores enable nbytes lanes starting at the offset; loads always read the full word.
  always_comb begin
    cmd_be = '0;
    for (int i = 0; i < BE_W; i++) begin
      cmd_be[i] = !cmd_op[OP_STORE] ||
                  ((i >= int'(cmd_off)) &&
                   (i < int'(cmd_off) + int'(size_bytes(cmd_op[1:0]))));
    end
  end

  lsu_mem_port_lane_ext #(.DATA_W(DATA_W)) u_lane_ext (
    .rdata_i    (mem_rsp_rdata),
    .off_i      (off_q),
    .size_i     (op_q[1:0]),
    .unsigned_i (op_q[OP_UNSIGNED]),
    .ext_o      (ext_data)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    off_d    = off_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = cmd_op;
          off_d   = cmd_off;
          addr_d  = {cmd_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          be_d    = cmd_be;
          wdata_d = cmd_op[OP_STORE] ? (cmd_wdata << {cmd_off, 3'b000}) : '0;
          if (is_fault(cmd_op, 3'(cmd_off), DATA_W == 64)) begin
            result_d = '0;
            state_d  = S_ERR;
          end else begin
            state_d  = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          if (op_q[OP_STORE]) begin
            result_d = '0;
            state_d  = S_DONE;
          end else begin
            state_d  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          result_d = ext_data;
          state_d  = S_DONE;
        end
      end
      S_DONE, S_ERR: state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values; blocking here would create order-dependent races between registers.
  always_ff @(posedge clk) begin
    // NOTE: every register, datapath included, is reset so the outputs read zero out of
    // reset and a request abandoned mid-flight leaves no stale lanes or data behind.
    if (!reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      off_q    <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      off_q    <= off_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      result_q <= result_d;
    end
  end

  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_we    = mem_req_valid && op_q[OP_STORE];
  assign mem_req_addr  = addr_q;
  assign mem_req_be    = be_q;
  assign mem_req_wdata = wdata_q;
  assign done_valid    = (state_q == S_DONE) || (state_q == S_ERR);
  assign done_err      = (state_q == S_ERR);
  assign done_rdata    = result_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: a 32-bit and a 64-bit instance driven by one linear
// sequence, each comparison an immediate assertion against hand-computed values.
module tb_lsu_mem_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  // 32-bit instance
  logic        a_cmd_valid, a_cmd_ready;
  logic [3:0]  a_cmd_op;
  logic [31:0] a_cmd_addr, a_cmd_wdata;
  logic        a_req_valid, a_req_ready, a_req_we;
  logic [31:0] a_req_addr, a_req_wdata;
  logic [3:0]  a_req_be;
  logic        a_rsp_valid;
  logic [31:0] a_rsp_rdata, a_done_rdata;
  logic        a_done_valid, a_done_err, a_busy;

  // 64-bit instance
  logic        b_cmd_valid, b_cmd_ready;
  logic [3:0]  b_cmd_op;
  logic [31:0] b_cmd_addr, b_req_addr;
  logic [63:0] b_cmd_wdata, b_req_wdata, b_rsp_rdata, b_done_rdata;
  logic        b_req_valid, b_req_ready, b_req_we;
  logic [7:0]  b_req_be;
  logic        b_rsp_valid;
  logic        b_done_valid, b_done_err, b_busy;

  lsu_mem_port #(.DATA_W(32), .ADDR_W(32)) u_dut32 (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_op(a_cmd_op),
    .cmd_addr(a_cmd_addr), .cmd_wdata(a_cmd_wdata),
    .mem_req_valid(a_req_valid), .mem_req_ready(a_req_ready), .mem_req_we(a_req_we),
    .mem_req_addr(a_req_addr), .mem_req_be(a_req_be), .mem_req_wdata(a_req_wdata),
    .mem_rsp_valid(a_rsp_valid), .mem_rsp_rdata(a_rsp_rdata),
    .done_valid(a_done_valid), .done_rdata(a_done_rdata), .done_err(a_done_err),
    .busy(a_busy)
  );

  lsu_mem_port #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_op(b_cmd_op),
    .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
    .mem_req_valid(b_req_valid), .mem_req_ready(b_req_ready), .mem_req_we(b_req_we),
    .mem_req_addr(b_req_addr), .mem_req_be(b_req_be), .mem_req_wdata(b_req_wdata),
    .mem_rsp_valid(b_rsp_valid), .mem_rsp_rdata(b_rsp_rdata),
    .done_valid(b_done_valid), .done_rdata(b_done_rdata), .done_err(b_done_err),
    .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;
  int a_done_cnt = 0;
  int snap;

  always @(negedge clk) if (a_done_valid) a_done_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n     = 1'b0;
    a_cmd_valid = 1'b0; a_cmd_op = '0; a_cmd_addr = '0; a_cmd_wdata = '0;
    a_req_ready = 1'b0; a_rsp_valid = 1'b0; a_rsp_rdata = '0;
    b_cmd_valid = 1'b0; b_cmd_op = '0; b_cmd_addr = '0; b_cmd_wdata = '0;
    b_req_ready = 1'b0; b_rsp_valid = 1'b0; b_rsp_rdata = '0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    check("rst_cmd_ready", a_cmd_ready, 1);
    check("rst_busy", a_busy, 0);
    check("rst_req_valid", a_req_valid, 0);
    check("rst_done_valid", a_done_valid, 0);
    check("rst_done_rdata", a_done_rdata, 0);
    check("rst_req_be", a_req_be, 0);
    check("rst64_cmd_ready", b_cmd_ready, 1);

    // LB 0x13, rdata 0x80FF_0000: byte 3 = 0x80, sign-extended
    a_cmd_valid = 1'b1; a_cmd_op = 4'b0000; a_cmd_addr = 32'h13;
    a_req_ready = 1'b1; a_rsp_valid = 1'b1; a_rsp_rdata = 32'h80FF_0000;
    tick();
    a_cmd_valid = 1'b0;
    check("lb_t1_req_valid", a_req_valid, 1);
    check("lb_t1_req_addr", a_req_addr, 32'h10);
    check("lb_t1_req_be", a_req_be, 4'hF);
    check("lb_t1_req_we", a_req_we, 0);
    check("lb_t1_cmd_ready", a_cmd_ready, 0);
    check("lb_t1_done", a_done_valid, 0);
    tick();
    check("lb_t2_req_valid", a_req_valid, 0);
    check("lb_t2_done", a_done_valid, 0);
    tick();
    check("lb_t3_done", a_done_valid, 1);
    check("lb_t3_err", a_done_err, 0);
    check("lb_t3_rdata", a_done_rdata, 32'hFFFF_FF80);
    tick();
    check("lb_after_done", a_done_valid, 0);
    check("lb_rdata_hold", a_done_rdata, 32'hFFFF_FF80);
    check("lb_after_ready", a_cmd_ready, 1);

    // LBU same address: zero-extended
    a_cmd_valid = 1'b1; a_cmd_op = 4'b0100;
    tick();
    a_cmd_valid = 1'b0;
    tick();
    tick();
    check("lbu_t3_done", a_done_valid, 1);
    check("lbu_t3_rdata", a_done_rdata, 32'h0000_0080);
    tick();

    // SH 0x102: lanes 2..3, done at t2 with zero data
    a_rsp_valid = 1'b0;
    a_cmd_valid = 1'b1; a_cmd_op = 4'b1001; a_cmd_addr = 32'h102; a_cmd_wdata = 32'h0000_BEEF;
    tick();
    a_cmd_valid = 1'b0;
    check("sh_req_valid", a_req_valid, 1);
    check("sh_req_we", a_req_we, 1);
    check("sh_req_addr", a_req_addr, 32'h100);
    check("sh_req_be", a_req_be, 4'b1100);
    check("sh_req_wdata", a_req_wdata, 32'hBEEF_0000);
    tick();
    check("sh_t2_done", a_done_valid, 1);
    check("sh_t2_err", a_done_err, 0);
    check("sh_t2_rdata", a_done_rdata, 0);
    tick();

    // LW 0x6: misaligned, error pulse without a memory request
    a_cmd_valid = 1'b1; a_cmd_op = 4'b0010; a_cmd_addr = 32'h6;
    tick();
    a_cmd_valid = 1'b0;
    check("lw_mis_done", a_done_valid, 1);
    check("lw_mis_err", a_done_err, 1);
    check("lw_mis_req", a_req_valid, 0);
    tick();
    check("lw_mis_after_done", a_done_valid, 0);
    check("lw_mis_after_req", a_req_valid, 0);
    check("lw_mis_after_ready", a_cmd_ready, 1);

    // SD on the 32-bit port is illegal
    a_cmd_valid = 1'b1; a_cmd_op = 4'b1011; a_cmd_addr = 32'h0;
    tick();
    a_cmd_valid = 1'b0;
    check("sd32_err", a_done_err, 1);
    check("sd32_req", a_req_valid, 0);
    tick();

    // LH 0x22 with a stalled request and a late response
    snap = a_done_cnt;
    a_req_ready = 1'b0; a_rsp_rdata = 32'h1234_5678;
    a_cmd_valid = 1'b1; a_cmd_op = 4'b0001; a_cmd_addr = 32'h22;
    tick();
    a_cmd_valid = 1'b0; a_cmd_addr = 32'hFFFF_FFFF; a_cmd_op = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      check("stall_req_valid", a_req_valid, 1);
      check("stall_req_addr", a_req_addr, 32'h20);
      check("stall_req_be", a_req_be, 4'hF);
      tick();
    end
    a_req_ready = 1'b1;
    check("stall_req_hold", a_req_valid, 1);
    tick();
    a_req_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("stall_wait_done", a_done_valid, 0);
      check("stall_wait_busy", a_busy, 1);
      tick();
    end
    a_rsp_valid = 1'b1;
    tick();
    a_rsp_valid = 1'b0;
    check("stall_done", a_done_valid, 1);
    check("stall_rdata", a_done_rdata, 32'h0000_1234);
    for (int k = 0; k < 4; k++) tick();
    check("stall_one_pulse", a_done_cnt - snap, 1);

    // 64-bit port: LW/LWU at offset 4 and a full-width LD
    b_req_ready = 1'b1; b_rsp_valid = 1'b1; b_rsp_rdata = 64'h8000_0001_0000_0000;
    b_cmd_valid = 1'b1; b_cmd_op = 4'b0010; b_cmd_addr = 32'h1004;
    tick();
    b_cmd_valid = 1'b0;
    check("lw64_req_addr", b_req_addr, 32'h1000);
    check("lw64_req_be", b_req_be, 8'hFF);
    tick();
    tick();
    check("lw64_done", b_done_valid, 1);
    check("lw64_rdata", b_done_rdata, 64'hFFFF_FFFF_8000_0001);
    tick();
    b_cmd_valid = 1'b1; b_cmd_op = 4'b0110;
    tick();
    b_cmd_valid = 1'b0;
    tick();
    tick();
    check("lwu64_rdata", b_done_rdata, 64'h0000_0000_8000_0001);
    tick();
    b_rsp_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    b_cmd_valid = 1'b1; b_cmd_op = 4'b0011; b_cmd_addr = 32'h1000;
    tick();
    b_cmd_valid = 1'b0;
    tick();
    tick();
    check("ld64_done", b_done_valid, 1);
    check("ld64_rdata", b_done_rdata, 64'hDEAD_BEEF_CAFE_F00D);
    tick();

    // Reset while waiting for a load response; the late response must be ignored
    a_req_ready = 1'b1; a_rsp_valid = 1'b0;
    a_cmd_valid = 1'b1; a_cmd_op = 4'b0010; a_cmd_addr = 32'h40;
    tick();
    a_cmd_valid = 1'b0;
    tick();
    check("rstw_busy_before", a_busy, 1);
    snap = a_done_cnt;
    reset_n = 1'b0;
    tick();
    check("rstw_busy", a_busy, 0);
    check("rstw_done", a_done_valid, 0);
    check("rstw_rdata", a_done_rdata, 0);
    check("rstw_req", a_req_valid, 0);
    reset_n = 1'b1;
    a_rsp_valid = 1'b1;
    #1;
    check("rstw_cmd_ready", a_cmd_ready, 1);
    for (int k = 0; k < 3; k++) tick();
    a_rsp_valid = 1'b0;
    check("rstw_no_done", a_done_cnt - snap, 0);
    check("rstw_idle", a_busy, 0);
    check("rstw_ready_after", a_cmd_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
